// File: rtl/cva5_types.sv
// Shared types for the wishbone masters of the L1 memory path.
// Cycle type and burst type codes live here so every master
// drives the same encodings.
package cva5_types;

  typedef enum logic [2:0] {
    WB_CTI_CLASSIC = 3'b000,
    WB_CTI_INCR    = 3'b010,
    WB_CTI_END     = 3'b111
  } wb_cti_t;

  typedef enum logic [1:0] {
    WB_BTE_LINEAR = 2'b00
  } wb_bte_t;

  // Cycle type for one beat of a read: classic for single words or when
  // bursting is disabled, otherwise incrementing until the last beat.
  function automatic wb_cti_t wb_read_cti(input logic burst_en,
                                          input logic [4:0] beat,
                                          input logic [4:0] len);
    if (!burst_en || (len == 5'd0)) begin
      return WB_CTI_CLASSIC;
    end else if (beat == len) begin
      return WB_CTI_END;
    end else begin
      return WB_CTI_INCR;
    end
  endfunction

endpackage

// File: rtl/l1_wishbone_bridge.sv
// Runs L1 arbiter requests as Wishbone B4 master cycles.
// Reads may be incrementing multi-word bursts and every beat is returned
// on the response port; writes are single word. Wishbone err terminates
// a beat like ack and latches a sticky bus_error flag.
module l1_wishbone_bridge #(
  parameter int USE_BURST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  // l1 arbiter request
  input  logic [31:0] l1_request_addr,
  input  logic [31:0] l1_request_data,
  input  logic        l1_request_rnw,
  input  logic [3:0]  l1_request_be,
  input  logic [4:0]  l1_request_size,
  input  logic        l1_request_is_amo,
  input  logic [4:0]  l1_request_amo,
  input  logic        l1_request_request,
  output logic        l1_request_ack,
  // l1 arbiter return
  output logic [31:0] l1_response_data,
  output logic        l1_response_data_valid,
  output logic [29:0] l1_response_inv_addr,
  output logic        l1_response_inv_valid,
  input  logic        l1_response_inv_ack,
  // wishbone master
  output logic [29:0] wishbone_adr,
  output logic [31:0] wishbone_dat_w,
  output logic [3:0]  wishbone_sel,
  output logic        wishbone_cyc,
  output logic        wishbone_stb,
  output logic        wishbone_we,
  output logic [2:0]  wishbone_cti,
  output logic [1:0]  wishbone_bte,
  input  logic [31:0] wishbone_dat_r,
  input  logic        wishbone_ack,
  input  logic        wishbone_err,
  // status
  output logic        bus_error
);
  import cva5_types::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic BURST_EN = (USE_BURST != 0);

  state_t      state_q, state_d;
  logic [4:0]  beat_q, beat_d;
  logic [4:0]  len_q, len_d;
  logic [29:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        data_valid_q, data_valid_d;
  logic        bus_error_q, bus_error_d;
  logic        term;
  wb_cti_t     cti_sel;

  // Byte offset, AMO fields and invalidation handshake play no role here.
  logic unused_inputs;
  assign unused_inputs = ^{l1_request_addr[1:0], l1_request_is_amo,
                           l1_request_amo, l1_response_inv_ack};

  // ack and err together still end just one beat.
  assign term = wishbone_ack | wishbone_err;

  // State and datapath registers; reset aborts any cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= 5'd0;
      len_q        <= 5'd0;
      base_q       <= 30'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      rdata_q      <= 32'd0;
      data_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rdata_q      <= rdata_d;
      data_valid_q <= data_valid_d;
      bus_error_q  <= bus_error_d;
    end
  end

  // Next state: latch a request in IDLE, count read beats, leave on the last termination.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    len_d        = len_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rdata_d      = rdata_q;
    data_valid_d = 1'b0;
    bus_error_d  = bus_error_q | wishbone_err;
    unique case (state_q)
      IDLE: begin
        if (l1_request_request) begin
          base_d  = l1_request_addr[31:2];
          wdata_d = l1_request_data;
          be_d    = l1_request_be;
          len_d   = l1_request_size;
          beat_d  = 5'd0;
          state_d = l1_request_rnw ? READ : WRITE;
        end
      end
      READ: begin
        if (term) begin
          rdata_d      = wishbone_dat_r;
          data_valid_d = 1'b1;
          if (beat_q == len_q) begin
            beat_d  = 5'd0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      WRITE: begin
        if (term) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs decoded from the registered state so reset drops them at once.
  always_comb begin
    l1_request_ack = 1'b0;
    wishbone_cyc   = 1'b0;
    wishbone_stb   = 1'b0;
    wishbone_we    = 1'b0;
    wishbone_sel   = 4'h0;
    wishbone_adr   = base_q + {25'd0, beat_q};
    wishbone_dat_w = wdata_q;
    cti_sel        = WB_CTI_CLASSIC;
    unique case (state_q)
      IDLE: begin
        l1_request_ack = rst_n & l1_request_request;
      end
      READ: begin
        wishbone_cyc = 1'b1;
        wishbone_stb = 1'b1;
        wishbone_sel = 4'hF;
        cti_sel      = wb_read_cti(BURST_EN, beat_q, len_q);
      end
      WRITE: begin
        wishbone_cyc = 1'b1;
        wishbone_stb = 1'b1;
        wishbone_we  = 1'b1;
        wishbone_adr = base_q;
        wishbone_sel = be_q;
      end
      default: begin
        l1_request_ack = 1'b0;
      end
    endcase
  end

  assign wishbone_cti           = cti_sel;
  assign wishbone_bte           = WB_BTE_LINEAR;
  assign l1_response_data       = rdata_q;
  assign l1_response_data_valid = data_valid_q;
  assign l1_response_inv_addr   = 30'd0;
  assign l1_response_inv_valid  = 1'b0;
  assign bus_error              = bus_error_q;

endmodule

// File: tb/tb_l1_wishbone_bridge.sv
// Bench for l1_wishbone_bridge: a burst and a classic instance share
// stimulus; a transaction-level model predicts every output each cycle.
module tb_l1_wishbone_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] req_addr = '0, req_data = '0;
  logic        req_rnw = 1'b0, req_is_amo = 1'b0, req_request = 1'b0, inv_ack = 1'b0;
  logic [3:0]  req_be = '0;
  logic [4:0]  req_size = '0, req_amo = '0;
  logic [31:0] wb_dat_r = '0;
  logic        wb_ack = 1'b0, wb_err = 1'b0;

  logic        ack_b, dv_b, invv_b, cyc_b, stb_b, we_b, berr_b;
  logic [31:0] data_b, datw_b;
  logic [29:0] inva_b, adr_b;
  logic [3:0]  sel_b;
  logic [2:0]  cti_b;
  logic [1:0]  bte_b;
  logic        ack_c, dv_c, invv_c, cyc_c, stb_c, we_c, berr_c;
  logic [31:0] data_c, datw_c;
  logic [29:0] inva_c, adr_c;
  logic [3:0]  sel_c;
  logic [2:0]  cti_c;
  logic [1:0]  bte_c;

  l1_wishbone_bridge #(.USE_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .l1_request_addr(req_addr), .l1_request_data(req_data), .l1_request_rnw(req_rnw),
    .l1_request_be(req_be), .l1_request_size(req_size), .l1_request_is_amo(req_is_amo),
    .l1_request_amo(req_amo), .l1_request_request(req_request), .l1_request_ack(ack_b),
    .l1_response_data(data_b), .l1_response_data_valid(dv_b), .l1_response_inv_addr(inva_b),
    .l1_response_inv_valid(invv_b), .l1_response_inv_ack(inv_ack),
    .wishbone_adr(adr_b), .wishbone_dat_w(datw_b), .wishbone_sel(sel_b), .wishbone_cyc(cyc_b),
    .wishbone_stb(stb_b), .wishbone_we(we_b), .wishbone_cti(cti_b), .wishbone_bte(bte_b),
    .wishbone_dat_r(wb_dat_r), .wishbone_ack(wb_ack), .wishbone_err(wb_err),
    .bus_error(berr_b)
  );

  l1_wishbone_bridge #(.USE_BURST(0)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .l1_request_addr(req_addr), .l1_request_data(req_data), .l1_request_rnw(req_rnw),
    .l1_request_be(req_be), .l1_request_size(req_size), .l1_request_is_amo(req_is_amo),
    .l1_request_amo(req_amo), .l1_request_request(req_request), .l1_request_ack(ack_c),
    .l1_response_data(data_c), .l1_response_data_valid(dv_c), .l1_response_inv_addr(inva_c),
    .l1_response_inv_valid(invv_c), .l1_response_inv_ack(inv_ack),
    .wishbone_adr(adr_c), .wishbone_dat_w(datw_c), .wishbone_sel(sel_c), .wishbone_cyc(cyc_c),
    .wishbone_stb(stb_c), .wishbone_we(we_c), .wishbone_cti(cti_c), .wishbone_bte(bte_c),
    .wishbone_dat_r(wb_dat_r), .wishbone_ack(wb_ack), .wishbone_err(wb_err),
    .bus_error(berr_c)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: bound expired at t=%0t", name, $time);
  endtask

  // Behavioural model: one outstanding transaction, tracked by beat index.
  bit          m_busy = 0, m_rnw = 0, m_dv = 0, m_berr = 0;
  logic [29:0] m_base = '0;
  int          m_len = 0, m_beat = 0;
  logic [31:0] m_wdata = '0, m_rdata = '0;
  logic [3:0]  m_be = '0;

  // Advance the model on each clock from the inputs seen at that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_dv = 0; m_berr = 0; m_beat = 0; m_rdata = '0;
    end else begin
      m_dv = 0;
      if (wb_err) m_berr = 1;
      if (!m_busy) begin
        if (req_request) begin
          m_busy = 1; m_rnw = req_rnw; m_base = req_addr[31:2];
          m_len = int'(req_size); m_beat = 0; m_wdata = req_data; m_be = req_be;
        end
      end else if (wb_ack || wb_err) begin
        if (m_rnw) begin
          m_dv = 1;
          m_rdata = wb_dat_r;
          if (m_beat == m_len) m_busy = 0;
          else m_beat = m_beat + 1;
        end else begin
          m_busy = 0;
        end
      end
    end
  end

  always @(posedge clk) cycle++;

  logic        exp_ack;
  logic [29:0] exp_adr;
  logic [3:0]  exp_sel;
  logic [2:0]  exp_cti_burst;

  task automatic check_dut(input string t, input logic ack, input logic dv, input logic [31:0] data,
                           input logic invv, input logic [29:0] inva, input logic cyc, input logic stb,
                           input logic we, input logic [29:0] adr, input logic [31:0] datw,
                           input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte,
                           input logic berr, input logic [2:0] ecti);
    check_output({t, ".ack"}, 32'(ack), 32'(exp_ack));
    check_output({t, ".cyc"}, 32'(cyc), 32'(m_busy));
    check_output({t, ".stb"}, 32'(stb), 32'(m_busy));
    check_output({t, ".we"}, 32'(we), 32'(m_busy && !m_rnw));
    check_output({t, ".data_valid"}, 32'(dv), 32'(m_dv));
    check_output({t, ".data"}, data, m_rdata);
    check_output({t, ".inv_valid"}, 32'(invv), 32'd0);
    check_output({t, ".inv_addr"}, 32'(inva), 32'd0);
    check_output({t, ".bte"}, 32'(bte), 32'd0);
    check_output({t, ".bus_error"}, 32'(berr), 32'(m_berr));
    if (m_busy) begin
      check_output({t, ".adr"}, 32'(adr), 32'(exp_adr));
      check_output({t, ".sel"}, 32'(sel), 32'(exp_sel));
      check_output({t, ".cti"}, 32'(cti), 32'(ecti));
      if (!m_rnw) check_output({t, ".dat_w"}, datw, m_wdata);
    end
  endtask

  // Compare both instances against the model every cycle, mid-period.
  always @(negedge clk) begin
    exp_ack = rst_n && !m_busy && req_request;
    exp_adr = m_rnw ? m_base + 30'(m_beat) : m_base;
    exp_sel = m_rnw ? 4'hF : m_be;
    if (!m_rnw || m_len == 0) exp_cti_burst = 3'b000;
    else if (m_beat == m_len) exp_cti_burst = 3'b111;
    else exp_cti_burst = 3'b010;
    check_dut("burst", ack_b, dv_b, data_b, invv_b, inva_b, cyc_b, stb_b, we_b, adr_b, datw_b,
              sel_b, cti_b, bte_b, berr_b, exp_cti_burst);
    check_dut("classic", ack_c, dv_c, data_c, invv_c, inva_c, cyc_c, stb_c, we_c, adr_c, datw_c,
              sel_c, cti_c, bte_c, berr_c, 3'b000);
  end

  // Monitor records terminated beats and returned data for literal checks.
  logic [31:0] mon_adr[$], mon_ctib[$], mon_ctic[$], mon_we[$], mon_sel[$], mon_datw[$], mon_data[$];
  int mon_term_cyc = 0, mon_req_ack_cyc = 0;

  always @(negedge clk) begin
    if (cyc_b && stb_b && (wb_ack || wb_err)) begin
      mon_adr.push_back(32'(adr_b));
      mon_ctib.push_back(32'(cti_b));
      mon_ctic.push_back(32'(cti_c));
      mon_we.push_back(32'(we_b));
      mon_sel.push_back(32'(sel_b));
      mon_datw.push_back(datw_b);
      mon_term_cyc = cycle;
    end
    if (dv_b) mon_data.push_back(data_b);
    if (ack_b) mon_req_ack_cyc = cycle;
  end

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 'x;
  endfunction

  // Wishbone slave: configurable wait states, scripted data, forced errors.
  bit          slv_rand = 0;
  int          slv_wait_cfg = 0, slv_err_pct = 0, slv_left = 0, slv_beat = 0;
  logic [31:0] slv_err_mask = '0;
  logic [31:0] slv_data[$];

  function automatic int next_wait();
    return slv_rand ? int'($urandom_range(3)) : slv_wait_cfg;
  endfunction

  // Slave reacts just after each edge to the cycle the bridge is presenting.
  always @(posedge clk) begin
    #1;
    if (!(cyc_b && stb_b)) begin
      wb_ack = 1'b0; wb_err = 1'b0; slv_beat = 0; slv_left = next_wait();
    end else if (slv_left == 0) begin
      wb_err = (slv_beat < 32 && slv_err_mask[5'(slv_beat)]) || (int'($urandom_range(99)) < slv_err_pct);
      wb_ack = !wb_err || (slv_rand && $urandom_range(1) == 1);
      wb_dat_r = (slv_data.size() > 0) ? slv_data.pop_front() : $urandom;
      slv_beat++;
      slv_left = next_wait();
    end else begin
      wb_ack = 1'b0; wb_err = 1'b0; slv_left--;
    end
  end

  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                                input logic rnw, input logic [4:0] size, output int waited);
    bit got = 0;
    req_addr = addr; req_data = data; req_be = be; req_rnw = rnw; req_size = size;
    req_is_amo = 1'($urandom_range(1)); req_amo = 5'($urandom);
    req_request = 1'b1;
    waited = 0;
    while (!got && waited <= 400) begin
      @(negedge clk);
      if (ack_b) got = 1;
      else waited++;
    end
    if (!got) timeout_fail("request_ack");
    @(posedge clk); #1;
    req_request = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (m_busy) timeout_fail("idle_wait");
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    mon_adr.delete(); mon_ctib.delete(); mon_ctic.delete(); mon_we.delete();
    mon_sel.delete(); mon_datw.delete(); mon_data.delete();
    @(posedge clk); #1;
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    int w, n;
    logic [4:0] sz;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst.adr", 32'(adr_b), 32'd0);
    check_output("rst.dat_w", datw_b, 32'd0);
    check_output("rst.sel", 32'(sel_b), 32'd0);
    check_output("rst.cti", 32'(cti_b), 32'd0);
    check_output("rst.cyc", 32'(cyc_b), 32'd0);
    check_output("rst.data", data_b, 32'd0);
    check_output("rst.bus_error", 32'(berr_b), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single read, slave answers two cycles after stb
    slv_wait_cfg = 2;
    slv_data.push_back(32'hDEADBEEF);
    clear_mon();
    apply_stimulus(32'h0000_1004, 32'd0, 4'hF, 1'b1, 5'd0, w);
    check_output("read.accept_wait", 32'(w), 32'd0);
    wait_idle();
    check_output("read.beats", 32'(mon_adr.size()), 32'd1);
    check_output("read.adr", qget(mon_adr, 0), 32'h401);
    check_output("read.cti", qget(mon_ctib, 0), 32'd0);
    check_output("read.valid_count", 32'(mon_data.size()), 32'd1);
    check_output("read.data", qget(mon_data, 0), 32'hDEADBEEF);
    check_output("read.cyc_after", 32'(cyc_b), 32'd0);

    // four-word burst, zero wait states
    slv_wait_cfg = 0;
    clear_mon();
    apply_stimulus(32'h0000_0100, 32'd0, 4'hF, 1'b1, 5'd3, w);
    wait_idle();
    check_output("burst.beats", 32'(mon_adr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_output("burst.adr", qget(mon_adr, i), 32'h40 + 32'(i));
      check_output("burst.cti", qget(mon_ctib, i), (i == 3) ? 32'd7 : 32'd2);
      check_output("burst.cti_classic", qget(mon_ctic, i), 32'd0);
    end
    check_output("burst.valid_count", 32'(mon_data.size()), 32'd4);

    // write followed by a queued read
    slv_wait_cfg = 1;
    clear_mon();
    apply_stimulus(32'h0000_2000, 32'h12345678, 4'b0110, 1'b0, 5'd0, w);
    apply_stimulus(32'h0000_3000, 32'd0, 4'hF, 1'b1, 5'd0, w);
    check_output("write.no_valid", 32'(mon_data.size()), 32'd0);
    check_output("write.next_ack_latency", 32'(mon_req_ack_cyc - mon_term_cyc), 32'd1);
    wait_idle();
    check_output("write.we", qget(mon_we, 0), 32'd1);
    check_output("write.adr", qget(mon_adr, 0), 32'h800);
    check_output("write.dat_w", qget(mon_datw, 0), 32'h12345678);
    check_output("write.sel", qget(mon_sel, 0), 32'h6);
    check_output("write.cti", qget(mon_ctib, 0), 32'd0);

    // error on first beat with wait states, then a clean write
    slv_wait_cfg = 3;
    slv_err_mask = 32'h1;
    clear_mon();
    apply_stimulus(32'h0000_0400, 32'd0, 4'hF, 1'b1, 5'd1, w);
    wait_idle();
    check_output("err.valid_count", 32'(mon_data.size()), 32'd2);
    check_output("err.bus_error", 32'(berr_b), 32'd1);
    slv_err_mask = '0;
    slv_wait_cfg = 0;
    clear_mon();
    apply_stimulus(32'h0000_0404, 32'hCAFEF00D, 4'hF, 1'b0, 5'd0, w);
    wait_idle();
    check_output("err.sticky", 32'(berr_b), 32'd1);
    check_output("err.sticky_classic", 32'(berr_c), 32'd1);

    // address wrap across the top of the word space
    clear_mon();
    apply_stimulus(32'hFFFF_FFFC, 32'd0, 4'hF, 1'b1, 5'd1, w);
    wait_idle();
    check_output("wrap.adr0", qget(mon_adr, 0), 32'h3FFF_FFFF);
    check_output("wrap.adr1", qget(mon_adr, 1), 32'h0);
    check_output("wrap.cti_classic0", qget(mon_ctic, 0), 32'd0);
    check_output("wrap.cti_classic1", qget(mon_ctic, 1), 32'd0);
    check_output("wrap.cti_burst1", qget(mon_ctib, 1), 32'd7);

    // asynchronous reset during beat two of an eight-word read
    slv_wait_cfg = 1;
    clear_mon();
    apply_stimulus(32'h0000_0500, 32'd0, 4'hF, 1'b1, 5'd7, w);
    n = 0;
    while (mon_adr.size() < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (mon_adr.size() < 2) timeout_fail("reset.reach_beat2");
    #2 rst_n = 1'b0;
    #1;
    check_output("reset.cyc_drop", 32'(cyc_b), 32'd0);
    check_output("reset.stb_drop", 32'(stb_b), 32'd0);
    check_output("reset.valid_drop", 32'(dv_b), 32'd0);
    check_output("reset.cyc_drop_classic", 32'(cyc_c), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_output("reset.bus_error_clear", 32'(berr_b), 32'd0);
    apply_stimulus(32'h0000_0600, 32'd0, 4'hF, 1'b1, 5'd0, w);
    check_output("reset.immediate_ack", 32'(w), 32'd0);
    wait_idle();

    // randomized traffic with random waits and occasional errors
    slv_rand = 1;
    slv_err_pct = 5;
    clear_mon();
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(9) < 7) sz = 5'($urandom_range(3));
      else if ($urandom_range(9) < 9) sz = 5'($urandom_range(15));
      else sz = 5'd31;
      apply_stimulus($urandom, $urandom, 4'($urandom), 1'($urandom_range(1)), sz, w);
      if ($urandom_range(3) == 0) wait_idle();
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
